// File: rtl/gcd_unit_if.sv
// Operand/result handshake bundle for gcd_unit: a valid/ready channel in each
// direction, plus the iteration counter that goes with each result.
interface gcd_unit_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = WIDTH + 1
);
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [CNT_W-1:0]   cycles;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, cycles
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, cycles
   );
endinterface

// File: rtl/gcd_unit.sv
// Iterative GCD engine with one operation in flight. MODE 0 runs subtractive
// Euclid and MODE 1 runs binary Stein. io.cycles counts CALC iterations and saturates.
module gcd_unit #(
   parameter int WIDTH = 16,
   parameter int MODE  = 0,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic      clk,
   input  logic      reset,
   gcd_unit_if.slave io
);
   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      res_d   = res_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               a_d     = io.in_data[WIDTH-1:0];
               b_d     = io.in_data[2*WIDTH-1:WIDTH];
               k_d     = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end

         CALC: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // k stays zero in MODE 0, so the shift is a no-op there.
            if (b_q == '0) begin
               res_d   = a_q << k_q;
               state_d = DONE;
            end else if (a_q == '0) begin
               res_d   = b_q << k_q;
               state_d = DONE;
            end else if (MODE == 0) begin
               if (a_q > b_q) begin
                  a_d = b_q;
                  b_d = a_q;
               end else begin
                  b_d = b_q - a_q;
               end
            end else begin
               if (!a_q[0] && !b_q[0]) begin
                  a_d = a_q >> 1;
                  b_d = b_q >> 1;
                  k_d = k_q + 1'b1;
               end else if (!a_q[0]) begin
                  a_d = a_q >> 1;
               end else if (!b_q[0]) begin
                  b_d = b_q >> 1;
               end else if (a_q >= b_q) begin
                  a_d = (a_q - b_q) >> 1;
               end else begin
                  b_d = (b_q - a_q) >> 1;
               end
            end
         end

         DONE: begin
            if (io.out_ready) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Both handshake outputs are pure state decodes, so neither depends on the opposite strobe.
   assign io.in_ready  = (state_q == IDLE);
   assign io.out_valid = (state_q == DONE);
   assign io.out_data  = res_q;
   assign io.cycles    = cnt_q;
endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit: five instances cover WIDTH 8/16, both modes,
// and a 4-bit saturating counter, all fed through a common driver/collector.
`timescale 1ns/1ps
module tb_gcd_unit;
   localparam int ND  = 5;
   localparam int DW [ND] = '{16, 16, 8, 8, 8};
   localparam int DM [ND] = '{0, 1, 0, 1, 0};
   localparam int DC [ND] = '{17, 17, 9, 9, 4};
   localparam int TMO = 1000;

   typedef struct packed {
      logic [15:0] res;
      logic [16:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [ND];
   logic [15:0] in_a      [ND];
   logic [15:0] in_b      [ND];
   logic        out_ready [ND];
   logic        in_ready  [ND];
   logic        out_valid [ND];
   logic [15:0] out_data  [ND];
   logic [16:0] cycles    [ND];

   exp_t sb [ND][$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : gen_dut
      localparam int W = DW[g];
      gcd_unit_if #(.WIDTH(W), .CNT_W(DC[g])) ifc ();
      gcd_unit #(.WIDTH(W), .MODE(DM[g]), .CNT_W(DC[g])) dut (
         .clk   (clk),
         .reset (rst_n),
         .io    (ifc.slave)
      );
      assign ifc.in_valid  = in_valid[g];
      assign ifc.in_data   = {in_b[g][W-1:0], in_a[g][W-1:0]};
      assign ifc.out_ready = out_ready[g];
      assign in_ready[g]   = ifc.in_ready;
      assign out_valid[g]  = ifc.out_valid;
      assign out_data[g]   = 16'(ifc.out_data);
      assign cycles[g]     = 17'(ifc.cycles);
   end

   function automatic logic [15:0] ref_gcd(input int unsigned a, input int unsigned b);
      int unsigned x = a;
      int unsigned y = b;
      int unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return 16'(x);
   endfunction

   // Iteration count of the chosen algorithm, one step per CALC cycle.
   function automatic int model_cycles(input int unsigned a0, input int unsigned b0, input int mode);
      int unsigned a = a0;
      int unsigned b = b0;
      int unsigned t;
      int n = 0;
      while (n < 100000) begin
         n++;
         if (b == 0 || a == 0) return n;
         if (mode == 0) begin
            if (a > b) begin t = a; a = b; b = t; end
            else b = b - a;
         end else if (a % 2 == 0 && b % 2 == 0) begin
            a = a / 2; b = b / 2;
         end else if (a % 2 == 0) a = a / 2;
         else if (b % 2 == 0) b = b / 2;
         else if (a >= b) a = (a - b) / 2;
         else b = (b - a) / 2;
      end
      return n;
   endfunction

   function automatic exp_t expect_of(input int d, input int unsigned a, input int unsigned b);
      exp_t e;
      int unsigned n    = int'(model_cycles(a, b, DM[d]));
      int unsigned maxc = (1 << DC[d]) - 1;
      e.res = ref_gcd(a, b);
      e.cyc = 17'((n > maxc) ? maxc : n);
      return e;
   endfunction

   // Presents one operand pair and returns just after the accepting edge.
   task automatic send(input int d, input logic [15:0] a, input logic [15:0] b,
                       output int waited, output bit to);
      waited = 0;
      to     = 1'b0;
      in_a[d]     = a;
      in_b[d]     = b;
      in_valid[d] = 1'b1;
      while (!in_ready[d]) begin
         @(posedge clk); #1;
         waited++;
         if (waited > TMO) begin
            to = 1'b1;
            in_valid[d] = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
   endtask

   // Waits for a result, captures it, then completes the output handshake.
   task automatic collect(input int d, output logic [15:0] data, output logic [16:0] cyc,
                          output int lat, output bit to);
      lat  = 0;
      to   = 1'b0;
      data = '0;
      cyc  = '0;
      out_ready[d] = 1'b0;
      while (!out_valid[d]) begin
         @(posedge clk); #1;
         lat++;
         if (lat > TMO) begin
            to = 1'b1;
            return;
         end
      end
      data = out_data[d];
      cyc  = cycles[d];
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < ND; d++) begin
         n_cmp += 4;
         if (in_ready[d] !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready dut%0d got %b expected 1", d, in_ready[d]); end
         if (out_valid[d] !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid dut%0d got %b expected 0", d, out_valid[d]); end
         if (out_data[d] !== 16'd0) begin n_mis++; $display("FAIL reset_out_data dut%0d got %0d expected 0", d, out_data[d]); end
         if (cycles[d] !== 17'd0) begin n_mis++; $display("FAIL reset_cycles dut%0d got %0d expected 0", d, cycles[d]); end
      end
   endtask

   typedef struct {
      int d;
      int a;
      int b;
      int res;
      int cyc;
   } vec_t;

   task automatic test_known_pairs();
      vec_t tbl [14] = '{
         '{0, 48, 18, 6, 9}, '{0, 18, 48, 6, 8}, '{0, 0, 0, 0, 1}, '{0, 5, 0, 5, 1}, '{0, 0, 7, 7, 1},
         '{1, 48, 18, 6, 7}, '{1, 18, 48, 6, 7}, '{1, 0, 0, 0, 1}, '{1, 5, 0, 5, 1}, '{1, 0, 7, 7, 1},
         '{2, 48, 18, 6, 9}, '{3, 48, 18, 6, 7}, '{2, 0, 0, 0, 1}, '{3, 0, 7, 7, 1}};
      logic [15:0] data;
      logic [16:0] cyc;
      int lat, waited;
      bit to;
      exp_t e;
      foreach (tbl[i]) begin
         e.res = 16'(tbl[i].res);
         e.cyc = 17'(tbl[i].cyc);
         sb[tbl[i].d].push_back(e);
         send(tbl[i].d, 16'(tbl[i].a), 16'(tbl[i].b), waited, to);
         if (!to) collect(tbl[i].d, data, cyc, lat, to);
         n_cmp++;
         if (to) begin
            n_mis++;
            $display("FAIL known_timeout dut%0d a=%0d b=%0d no result", tbl[i].d, tbl[i].a, tbl[i].b);
            sb[tbl[i].d].delete();
            continue;
         end
         e = sb[tbl[i].d].pop_front();
         n_cmp += 3;
         if (data !== e.res) begin n_mis++; $display("FAIL known_data dut%0d a=%0d b=%0d got %0d expected %0d", tbl[i].d, tbl[i].a, tbl[i].b, data, e.res); end
         if (cyc !== e.cyc) begin n_mis++; $display("FAIL known_cycles dut%0d a=%0d b=%0d got %0d expected %0d", tbl[i].d, tbl[i].a, tbl[i].b, cyc, e.cyc); end
         // Accepting edge plus the edges until valid: CALC cycles + 1.
         if (lat + 1 !== tbl[i].cyc + 1) begin n_mis++; $display("FAIL known_latency dut%0d a=%0d b=%0d got %0d expected %0d", tbl[i].d, tbl[i].a, tbl[i].b, lat + 1, tbl[i].cyc + 1); end
      end
   endtask

   task automatic test_hold();
      logic [15:0] data;
      logic [16:0] cyc;
      int lat, waited, w, bad;
      bit to;
      exp_t e;
      e.res = 16'd6;
      e.cyc = 17'd9;
      sb[0].push_back(e);
      send(0, 16'd48, 16'd18, waited, to);
      out_ready[0] = 1'b0;
      w = 0;
      while (!out_valid[0] && w < TMO) begin @(posedge clk); #1; w++; end
      n_cmp++;
      if (!out_valid[0]) begin n_mis++; $display("FAIL hold_timeout got no valid expected valid"); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid[0] !== 1'b1 || out_data[0] !== 16'd6 || cycles[0] !== 17'd9 || in_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable cycle %0d got v=%b d=%0d c=%0d r=%b expected v=1 d=6 c=9 r=0",
                     i, out_valid[0], out_data[0], cycles[0], in_ready[0]);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bad != 0) n_mis++;
      data = out_data[0];
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      e = sb[0].pop_front();
      n_cmp += 3;
      if (data !== e.res) begin n_mis++; $display("FAIL hold_data got %0d expected %0d", data, e.res); end
      if (in_ready[0] !== 1'b1) begin n_mis++; $display("FAIL hold_release_ready got %b expected 1", in_ready[0]); end
      if (out_valid[0] !== 1'b0) begin n_mis++; $display("FAIL hold_release_valid got %b expected 0", out_valid[0]); end
      sb[0].push_back(expect_of(0, 100, 75));
      send(0, 16'd100, 16'd75, waited, to);
      n_cmp++;
      if (waited !== 0 || to) begin n_mis++; $display("FAIL hold_next_accept waited %0d cycles expected 0", waited); end
      collect(0, data, cyc, lat, to);
      e = sb[0].pop_front();
      n_cmp += 2;
      if (data !== e.res) begin n_mis++; $display("FAIL hold_next_data got %0d expected %0d", data, e.res); end
      if (cyc !== e.cyc) begin n_mis++; $display("FAIL hold_next_cycles got %0d expected %0d", cyc, e.cyc); end
   endtask

   task automatic test_reset_mid_calc();
      logic [15:0] data;
      logic [16:0] cyc;
      int lat, waited;
      bit to;
      exp_t e;
      send(0, 16'd65535, 16'd1, waited, to);
      repeat (5) begin @(posedge clk); #1; end
      n_cmp++;
      if (out_valid[0] !== 1'b0) begin n_mis++; $display("FAIL midcalc_busy got valid %b expected 0", out_valid[0]); end
      rst_n = 1'b0;
      #1;
      n_cmp += 4;
      if (in_ready[0] !== 1'b1) begin n_mis++; $display("FAIL midcalc_in_ready got %b expected 1", in_ready[0]); end
      if (out_valid[0] !== 1'b0) begin n_mis++; $display("FAIL midcalc_out_valid got %b expected 0", out_valid[0]); end
      if (out_data[0] !== 16'd0) begin n_mis++; $display("FAIL midcalc_out_data got %0d expected 0", out_data[0]); end
      if (cycles[0] !== 17'd0) begin n_mis++; $display("FAIL midcalc_cycles got %0d expected 0", cycles[0]); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      sb[0].push_back(expect_of(0, 12, 18));
      send(0, 16'd12, 16'd18, waited, to);
      collect(0, data, cyc, lat, to);
      e = sb[0].pop_front();
      n_cmp += 2;
      if (data !== e.res) begin n_mis++; $display("FAIL midcalc_after_data got %0d expected %0d", data, e.res); end
      if (cyc !== e.cyc) begin n_mis++; $display("FAIL midcalc_after_cycles got %0d expected %0d", cyc, e.cyc); end
   endtask

   task automatic test_saturation();
      logic [15:0] data;
      logic [16:0] cyc;
      int lat, waited;
      bit to;
      exp_t e;
      e.res = 16'd1;
      e.cyc = 17'd15;
      sb[4].push_back(e);
      send(4, 16'd255, 16'd1, waited, to);
      collect(4, data, cyc, lat, to);
      e = sb[4].pop_front();
      n_cmp += 2;
      if (data !== e.res) begin n_mis++; $display("FAIL sat_data got %0d expected %0d", data, e.res); end
      if (cyc !== e.cyc) begin n_mis++; $display("FAIL sat_cycles got %0d expected %0d", cyc, e.cyc); end
   endtask

   task automatic test_back_to_back(input int d, input int n);
      fork
         begin : driver
            for (int i = 0; i < n; i++) begin
               int unsigned a, b;
               int w;
               if (DW[d] == 16) begin
                  int unsigned g = $urandom_range(1, 255);
                  a = g * $urandom_range(0, 255);
                  b = g * $urandom_range(0, 255);
               end else begin
                  a = $urandom_range(0, 255);
                  b = $urandom_range(0, 255);
               end
               in_a[d]     = 16'(a);
               in_b[d]     = 16'(b);
               in_valid[d] = 1'b1;
               w = 0;
               while (!in_ready[d] && w < TMO) begin @(posedge clk); #1; w++; end
               if (!in_ready[d]) begin
                  in_valid[d] = 1'b0;
                  break;
               end
               sb[d].push_back(expect_of(d, a, b));
               @(posedge clk); #1;
               in_valid[d] = 1'b0;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
         begin : monitor
            int got = 0;
            int w = 0;
            exp_t e;
            while (got < n && w < TMO * n) begin
               out_ready[d] = ($urandom_range(0, 3) != 0);
               if (out_valid[d] && out_ready[d]) begin
                  if (sb[d].size() == 0) begin
                     n_cmp++;
                     n_mis++;
                     $display("FAIL b2b_extra dut%0d got result %0d expected none", d, out_data[d]);
                  end else begin
                     e = sb[d].pop_front();
                     n_cmp += 2;
                     if (out_data[d] !== e.res) begin n_mis++; $display("FAIL b2b_data dut%0d got %0d expected %0d", d, out_data[d], e.res); end
                     if (cycles[d] !== e.cyc) begin n_mis++; $display("FAIL b2b_cycles dut%0d got %0d expected %0d", d, cycles[d], e.cyc); end
                  end
                  got++;
               end
               @(posedge clk); #1;
               w++;
            end
            out_ready[d] = 1'b0;
            n_cmp++;
            if (got != n) begin n_mis++; $display("FAIL b2b_count dut%0d got %0d expected %0d", d, got, n); end
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++;
      if (sb[d].size() != 0 || out_valid[d] !== 1'b0) begin
         n_mis++;
         $display("FAIL b2b_leftover dut%0d got pending=%0d valid=%b expected 0 and 0", d, sb[d].size(), out_valid[d]);
      end
      sb[d].delete();
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         in_valid[d]  = 1'b0;
         in_a[d]      = '0;
         in_b[d]      = '0;
         out_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_known_pairs();
      test_hold();
      test_reset_mid_calc();
      test_saturation();
      test_back_to_back(0, 12);
      test_back_to_back(1, 12);
      test_back_to_back(2, 20);
      test_back_to_back(3, 20);
      test_back_to_back(4, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
